// File: rtl/addr_dec_pkg.sv
// Shared state encoding and sizing helper for the serial address decoder.
package addr_dec_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_ADDR    = 3'd1;
  localparam logic [2:0] ST_DECODE  = 3'd2;
  localparam logic [2:0] ST_WAIT    = 3'd3;
  localparam logic [2:0] ST_CONNECT = 3'd4;
  localparam logic [2:0] ST_ERROR   = 3'd5;

  // Ceiling log2, never below 1 so it can size a vector directly.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/addr_decoder_n_decn.sv
// One-hot decoder: out[sel] = en, every other bit 0.
module decn #(
  parameter int NUM_SLAVES = 3,
  parameter int SSEL_W     = 2
) (
  input  logic [SSEL_W-1:0]     sel,
  input  logic                  en,
  output logic [NUM_SLAVES-1:0] out
);

  for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_out
    assign out[i] = en && (sel == SSEL_W'(i));
  end

endmodule

// File: rtl/addr_decoder_n.sv
// Serial address decoder: shifts in a device address LSB first, then connects the master
// to one slave. Optional WAIT timeout under `ADDR_DEC_TIMEOUT_EN.
module addr_decoder_n
  import addr_dec_pkg::*;
#(
  parameter int DEVICE_ADDR_WIDTH = 4,
  parameter int NUM_SLAVES        = 3,
  parameter int SSEL_W            = clog2(NUM_SLAVES),
  parameter int TIMEOUT_CYCLES    = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  mwdata,
  input  logic                  mvalid,
  input  logic [NUM_SLAVES-1:0] sready,
  output logic [NUM_SLAVES-1:0] mvalid_o,
  output logic [SSEL_W-1:0]     ssel,
  output logic                  ack,
  output logic                  derr
);

  // Counter is sized for both the address index and the WAIT timeout in every build.
  localparam int CNT_A = clog2(DEVICE_ADDR_WIDTH);
  localparam int CNT_T = clog2(TIMEOUT_CYCLES);
  localparam int CNT_W = (CNT_A > CNT_T) ? CNT_A : CNT_T;

  logic [2:0]                   state_q, state_d;
  logic [DEVICE_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;
  logic [SSEL_W-1:0]            ssel_q, ssel_d;
  logic                         miss, ready_addr, ready_ssel;

  assign miss = (32'(addr_q) >= 32'(NUM_SLAVES));

  always_comb begin
    ready_addr = 1'b0;
    ready_ssel = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (addr_q[SSEL_W-1:0] == SSEL_W'(i)) ready_addr = sready[i];
      if (ssel_q == SSEL_W'(i))             ready_ssel = sready[i];
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    ssel_d  = ssel_q;
    case (state_q)
      ST_IDLE: begin
        if (mvalid) begin
          addr_d    = '0;
          addr_d[0] = mwdata;
          if (DEVICE_ADDR_WIDTH == 1) begin
            state_d = ST_DECODE;
          end else begin
            state_d = ST_ADDR;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_ADDR: begin
        if (!mvalid) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          cnt_d   = '0;
        end else begin
          for (int i = 0; i < DEVICE_ADDR_WIDTH; i++)
            if (cnt_q == CNT_W'(i)) addr_d[i] = mwdata;
          if (cnt_q == CNT_W'(DEVICE_ADDR_WIDTH - 1)) begin
            state_d = ST_DECODE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DECODE: begin
        if (!mvalid) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          cnt_d   = '0;
        end else if (miss) begin
          state_d = ST_ERROR;
        end else begin
          ssel_d  = addr_q[SSEL_W-1:0];
          state_d = ready_addr ? ST_CONNECT : ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!mvalid) begin
          state_d = ST_IDLE;
          addr_d  = '0;
          cnt_d   = '0;
        end else if (ready_ssel) begin
          state_d = ST_CONNECT;
          cnt_d   = '0;
        end
`ifdef ADDR_DEC_TIMEOUT_EN
        // Ready on the expiry cycle is caught above, so CONNECT wins the tie.
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_ERROR;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_CONNECT, ST_ERROR: begin
        if (!mvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      ssel_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      ssel_q  <= ssel_d;
    end
  end

  assign ssel = ssel_q;
  assign ack  = (state_q == ST_CONNECT);
  assign derr = (state_q == ST_ERROR);

  decn #(
    .NUM_SLAVES(NUM_SLAVES),
    .SSEL_W    (SSEL_W)
  ) u_decn (
    .sel(ssel_q),
    .en (mvalid && (state_q == ST_CONNECT)),
    .out(mvalid_o)
  );

endmodule
